// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pkg                                                   |
// | Purpose  : Shared function codes, FSM state encoding and default     |
// |            word size for the multi-cycle ALU.                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int WORD_SIZE = 16;

  // Single-cycle function set inherited from the datapath ALU
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_ORR = 5'd3;
  localparam logic [4:0] ALU_NOT = 5'd4;
  localparam logic [4:0] ALU_TCP = 5'd5;
  localparam logic [4:0] ALU_SHL = 5'd6;
  localparam logic [4:0] ALU_SHR = 5'd7;
  localparam logic [4:0] ALU_BNE = 5'd8;
  localparam logic [4:0] ALU_BEQ = 5'd9;
  localparam logic [4:0] ALU_BGZ = 5'd10;
  localparam logic [4:0] ALU_BLZ = 5'd11;
  // Iterative operations
  localparam logic [4:0] ALU_MUL = 5'd12;
  localparam logic [4:0] ALU_DIV = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_iter_core                                             |
// | Purpose  : Shared iterative datapath: unsigned shift-add multiply    |
// |            and unsigned restoring divide, one bit per cycle.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alu_iter_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  // acc: product high word / partial remainder
  // sh : multiplier being consumed LSB-first / dividend shifting out MSB-first
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q;
  logic             div_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   w_lhs;
  logic [WIDTH:0]   w_rhs;
  logic [WIDTH:0]   w_sum;
  logic             w_ge;

  // One adder serves both ops: add the multiplicand, or subtract the divisor
  always_comb begin
    w_lhs = div_q ? {acc_q, sh_q[WIDTH-1]} : {1'b0, acc_q};
    if (div_q)
      w_rhs = ~{1'b0, opnd_q};
    else if (sh_q[0])
      w_rhs = {1'b0, opnd_q};
    else
      w_rhs = '0;
    w_sum = w_lhs + w_rhs + {{WIDTH{1'b0}}, div_q};
    // Top bit of the difference is the borrow: clear means the divisor fits
    w_ge  = ~w_sum[WIDTH];
    if (div_q) begin
      acc_d = w_ge ? w_sum[WIDTH-1:0] : w_lhs[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], w_ge};
    end else begin
      acc_d = w_sum[WIDTH:1];
      sh_d  = {w_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Final iteration is the one taken while the counter shows WIDTH-1
  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign lo_o   = sh_d;
  assign hi_o   = acc_d;

  // Operand load on start, then one shift/add-or-subtract step per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      acc_q  <= '0;
      sh_q   <= a_i;
      opnd_q <= b_i;
      div_q  <= div_i;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_multicycle                                            |
// | Purpose  : Multi-cycle ALU with valid/ready handshake; single-cycle  |
// |            ops plus iterative MUL/DIV, results held until consumed.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [4:0]       func_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_result,
  output logic [WIDTH-1:0] hi_result,
  output logic             b_result,
  output logic             error
);

  alu_state_e       state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi_q;
  logic             b_q;
  logic             err_q;

  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_hi;
  logic             w_b;
  logic             w_err;
  logic             w_mul;
  logic             w_div;
  logic             w_core_done;
  logic [WIDTH-1:0] w_core_lo;
  logic [WIDTH-1:0] w_core_hi;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // Decode the request: single-cycle results, or which iterative op to start
  always_comb begin
    w_a   = '0;
    w_hi  = '0;
    w_b   = 1'b0;
    w_err = 1'b0;
    w_mul = 1'b0;
    w_div = 1'b0;
    case (func_code)
      ALU_ADD: w_a = op1 + op2;
      ALU_SUB: w_a = op1 - op2;
      ALU_AND: w_a = op1 & op2;
      ALU_ORR: w_a = op1 | op2;
      ALU_NOT: w_a = ~op1;
      ALU_TCP: w_a = ~op1 + WIDTH'(1);
      ALU_SHL: w_a = {op1[WIDTH-2:0], 1'b0};
      ALU_SHR: w_a = {op1[WIDTH-1], op1[WIDTH-1:1]};
      ALU_BNE: w_b = (op1 != op2);
      ALU_BEQ: w_b = (op1 == op2);
      ALU_BGZ: w_b = !op1[WIDTH-1] && (op1 != '0);
      ALU_BLZ: w_b = op1[WIDTH-1];
      ALU_MUL: w_mul = 1'b1;
      ALU_DIV: begin
        if (op2 == '0) begin
          // Divide-by-zero resolves immediately, no iteration
          w_a   = '1;
          w_hi  = op1;
          w_err = 1'b1;
        end else begin
          w_div = 1'b1;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  alu_iter_core #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (reset_n),
    .start_i (w_accept && (w_mul || w_div)),
    .div_i   (w_div),
    .a_i     (op1),
    .b_i     (op2),
    .done_o  (w_core_done),
    .lo_o    (w_core_lo),
    .hi_o    (w_core_hi)
  );

  // Control FSM and result registers; results move only on accept or final iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      hi_q        <= '0;
      b_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_mul) begin
              state_q     <= ST_MUL;
              out_valid_q <= 1'b0;
            end else if (w_div) begin
              state_q     <= ST_DIV;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              a_q         <= w_a;
              hi_q        <= w_hi;
              b_q         <= w_b;
              err_q       <= w_err;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_core_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            a_q         <= w_core_lo;
            hi_q        <= w_core_hi;
            b_q         <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign a_result  = a_q;
  assign hi_result = hi_q;
  assign b_result  = b_q;
  assign error     = err_q;

endmodule
`default_nettype wire
